// File: rtl/neander_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neander_mem_pkg : shared types and helpers for the Neander program memory
// Revision 1.0
// ---------------------------------------------------------------------------
package neander_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BASE = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5
    } loader_state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // A frame is good when the running data sum plus the checksum word is zero mod 2**w.
    function automatic logic frame_good(input logic [31:0] acc,
                                        input logic [31:0] csum,
                                        input int unsigned w);
        logic [31:0] sum;
        logic [31:0] mask;
        sum  = acc + csum;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (sum & mask) == 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/neander_ram_2r1w.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neander_ram_2r1w : RAM with two asynchronous read ports, one synchronous write
// Revision 1.0
// ---------------------------------------------------------------------------
module neander_ram_2r1w #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/neander_prog_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// neander_prog_mem : Neander program/data memory with framed, checksummed loader
// Revision 1.0
// ---------------------------------------------------------------------------
module neander_prog_mem
    import neander_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_hold,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    // One extra count bit so LEN=0 can stand for the full memory depth.
    localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    if (DATA_W < ADDR_W) begin : g_bad_width
        $error("neander_prog_mem: DATA_W must be >= ADDR_W");
    end

    loader_state_t     state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic              s_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              w_beat;
    logic              w_good;
    logic              w_ldr_we;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_beat = s_valid && s_ready_q;
    assign w_good = frame_good(32'(acc_q), 32'(s_data), DATA_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_beat && (s_data == SYNC_WORD)) begin
                        state_q <= ST_BASE;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                ST_BASE: begin
                    if (w_beat) begin
                        ptr_q   <= s_data[ADDR_W-1:0];
                        state_q <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (w_beat) begin
                        cnt_q   <= (s_data[ADDR_W-1:0] == '0) ? FULL_DEPTH
                                                              : {1'b0, s_data[ADDR_W-1:0]};
                        acc_q   <= '0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                        acc_q <= acc_q + s_data;
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_beat) begin
                        state_q   <= ST_DONE;
                        s_ready_q <= 1'b0;
                        done_q    <= w_good;
                        if (!w_good) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Loader owns the write port for the whole frame; the CPU only writes when idle.
    assign w_ldr_we = w_beat && (state_q == ST_DATA);
    assign w_we     = w_ldr_we || (cpu_we && !busy_q);
    assign w_waddr  = w_ldr_we ? ptr_q  : cpu_addr;
    assign w_wdata  = w_ldr_we ? s_data : cpu_wdata;

    neander_ram_2r1w #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk       (clk),
        .we_i      (w_we),
        .waddr_i   (w_waddr),
        .wdata_i   (w_wdata),
        .raddr_a_i (cpu_addr),
        .rdata_a_o (cpu_rdata),
        .raddr_b_i (dbg_addr),
        .rdata_b_o (dbg_rdata)
    );

    assign s_ready   = s_ready_q;
    assign load_busy = busy_q;
    assign cpu_hold  = busy_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_neander_prog_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_neander_prog_mem : scoreboard bench for the Neander program memory loader
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_neander_prog_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       load_busy;
    logic       load_done;
    logic       load_err;
    logic       cpu_hold;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_we;
    logic [7:0] cpu_rdata;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_rdata;

    neander_prog_mem dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .cpu_hold  (cpu_hold),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_t;

    sb_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  done_cnt = 0;

    always @(negedge clk) begin
        if (load_done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_addr = e.addr;
            cpu_addr = e.addr;
            #1;
            check_eq({tag, "_dbg"}, 32'(dbg_rdata), 32'(e.data));
            check_eq({tag, "_cpu"}, 32'(cpu_rdata), 32'(e.data));
        end
    endtask

    // Full frame; bench derives goodness from its own sum of the data words.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] len,
                              input logic [7:0] d[$], input logic [7:0] csum,
                              input bit gaps, input bit drop_cpu_we);
        int   sum;
        int   done0;
        bit   good;
        sum = 0;
        foreach (d[i]) sum += int'(d[i]);
        good  = ((sum + int'(csum)) % 256) == 0;
        done0 = done_cnt;
        send_beat(8'hA5, gaps);
        check_eq("hold_after_sync", 32'(cpu_hold), 32'd1);
        check_eq("err_clr_on_sync", 32'(load_err), 32'd0);
        send_beat(base, gaps);
        send_beat(len, gaps);
        for (int i = 0; i < d.size(); i++) begin
            send_beat(d[i], gaps);
            sb.push_back('{addr: base + 8'(i), data: d[i]});
            if (i == 0) begin
                dbg_addr = base;
                #1;
                check_eq("wr_latency", 32'(dbg_rdata), 32'(d[0]));
            end
        end
        send_beat(csum, gaps);
        if (drop_cpu_we) cpu_we = 1'b0;
        check_eq("done_ready_low", 32'(s_ready), 32'd0);
        check_eq("done_pulse", 32'(load_done), 32'(good));
        check_eq("done_busy", 32'(load_busy), 32'd1);
        @(posedge clk);
        #1;
        check_eq("idle_ready", 32'(s_ready), 32'd1);
        check_eq("idle_busy", 32'(cpu_hold), 32'd0);
        check_eq("idle_done", 32'(load_done), 32'd0);
        check_eq("err_flag", 32'(load_err), 32'(!good));
        check_eq("done_count", 32'(done_cnt - done0), 32'(good));
    endtask

    initial begin
        logic [7:0] d[$];
        logic [7:0] cs;
        int         sum;
        int         done0;

        reset = 1'b1; s_valid = 1'b0; s_data = '0;
        cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_ready", 32'(s_ready), 32'd1);
        check_eq("rst_busy", 32'(load_busy), 32'd0);
        check_eq("rst_done", 32'(load_done), 32'd0);
        check_eq("rst_err", 32'(load_err), 32'd0);
        check_eq("rst_hold", 32'(cpu_hold), 32'd0);

        d = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h10, 8'h03, d, 8'h9A, 1'b0, 1'b0);
        drain("good");

        send_frame(8'h10, 8'h03, d, 8'h00, 1'b0, 1'b0);
        drain("bad");

        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(8'hFE, 8'h04, d, 8'hF6, 1'b1, 1'b0);
        drain("wrap");

        send_beat(8'h00, 1'b0);
        send_beat(8'hFF, 1'b0);
        check_eq("garbage_idle", 32'(load_busy), 32'd0);
        d = {};
        sum = 0;
        for (int i = 0; i < 256; i++) begin
            d.push_back(8'($urandom_range(0, 255)));
            sum += int'(d[i]);
        end
        cs = 8'((256 - (sum % 256)) % 256);
        send_frame(8'h40, 8'h00, d, cs, 1'b0, 1'b0);
        drain("full");

        d = '{8'hC1, 8'hC2, 8'hC3};
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hEE;
        send_frame(8'h10, 8'h03, d, 8'h3A, 1'b0, 1'b1);
        drain("arb");
        @(negedge clk);
        cpu_addr = 8'h10; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        check_eq("cpu_write", 32'(cpu_rdata), 32'h5A);

        done0 = done_cnt;
        send_beat(8'hA5, 1'b1);
        send_beat(8'h20, 1'b1);
        send_beat(8'h03, 1'b1);
        send_beat(8'h77, 1'b1);
        sb.push_back('{addr: 8'h20, data: 8'h77});
        send_beat(8'h88, 1'b1);
        sb.push_back('{addr: 8'h21, data: 8'h88});
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("midrst_busy", 32'(load_busy), 32'd0);
        check_eq("midrst_ready", 32'(s_ready), 32'd1);
        check_eq("midrst_err", 32'(load_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("midrst_nodone", 32'(done_cnt - done0), 32'd0);
        drain("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
